mem_access_ctrl: RTL and testbench

Parametrised MAR/MDR memory-access engine, the next generation of the memory-system datapath. It holds the memory address register and memory data register and drives an external synchronous memory port. It runs single or burst read/write transactions with a configurable number of wait states, post-incrementing MAR after each beat. It sits between the register bank/ALU bus and data memory, and replaces hand-sequenced `mar_en`/`mdr_en`/`wr_rdn` toggling with a request/done handshake.

---
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory-access engine: single or burst reads/writes over a synchronous memory port.
// Each beat takes WAIT_STATES+1 cycles; req/mar_en/mdr_en are ignored while busy.
module mem_access_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mar_sclr,
    input  logic                  mar_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  mdr_en,
    input  logic [DATA_WIDTH-1:0] alu_in,
    input  logic                  mdr_alu_n,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  req,
    input  logic                  wr_rdn,
    input  logic [1:0]            burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  beat_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mar_m,
    output logic [DATA_WIDTH-1:0] mdr_m
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] mar, mar_nxt;
    logic [DATA_WIDTH-1:0] mdr, mdr_nxt;
    logic [3:0]            wcnt, wcnt_nxt;
    logic [1:0]            bl, bl_nxt;
    logic                  wr_q, wr_nxt;
    logic                  beat_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            mar   <= '0;
            mdr   <= '0;
            wcnt  <= '0;
            bl    <= '0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            mar   <= mar_nxt;
            mdr   <= mdr_nxt;
            wcnt  <= wcnt_nxt;
            bl    <= bl_nxt;
            wr_q  <= wr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mar_nxt   = mar;
        mdr_nxt   = mdr;
        wcnt_nxt  = wcnt;
        bl_nxt    = bl;
        wr_nxt    = wr_q;
        beat_end  = (state == S_ACCESS) && (wcnt == 4'd0);
        case (state)
            S_IDLE: begin
                if (mar_sclr)
                    mar_nxt = '0;
                else if (mar_en)
                    mar_nxt = addr_in;
                if (mdr_en)
                    mdr_nxt = alu_in;
                if (req) begin
                    wr_nxt    = wr_rdn;
                    bl_nxt    = burst_len;
                    wcnt_nxt  = WS_INIT;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wcnt != 4'd0) begin
                    wcnt_nxt = wcnt - 4'd1;
                end else begin
                    if (!wr_q)
                        mdr_nxt = mem_rdata;
                    mar_nxt = mar + 1'b1;
                    if (bl == 2'd0) begin
                        state_nxt = S_FINISH;
                    end else begin
                        bl_nxt   = bl - 2'd1;
                        wcnt_nxt = WS_INIT;
                    end
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Pulses are masked by rst so an abort never shows a completion or a read beat.
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FINISH) && !rst;
    assign beat_valid = beat_end && !wr_q && !rst;
    assign mem_re     = (state == S_ACCESS) && !wr_q;
    assign mem_we     = beat_end && wr_q;
    assign mem_addr   = mar;
    assign mem_wdata  = mdr;
    assign mar_m      = mar;
    assign mdr_m      = mdr;
    assign data_out   = mdr_alu_n ? mdr : alu_in;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: instance 0 runs with one wait state, instance 1 with none;
// expectations come from beat/cycle arithmetic against a tracked MAR/MDR model.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       mar_sclr [2];
    logic       mar_en [2];
    logic [7:0] addr_in [2];
    logic       mdr_en [2];
    logic [7:0] alu_in [2];
    logic       mdr_alu_n [2];
    logic [7:0] data_out [2];
    logic       req [2];
    logic       wr_rdn [2];
    logic [1:0] burst_len [2];
    logic       busy [2];
    logic       done [2];
    logic       beat_valid [2];
    logic [7:0] mem_addr [2];
    logic [7:0] mem_wdata [2];
    logic       mem_re [2];
    logic       mem_we [2];
    logic [7:0] mem_rdata [2];
    logic [7:0] mar_m [2];
    logic [7:0] mdr_m [2];

    logic [7:0] key [2];
    logic [7:0] mar_e [2];
    logic [7:0] mdr_e [2];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ctrl #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (8),
            .WAIT_STATES(g == 0 ? 1 : 0)
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .mar_sclr  (mar_sclr[g]),
            .mar_en    (mar_en[g]),
            .addr_in   (addr_in[g]),
            .mdr_en    (mdr_en[g]),
            .alu_in    (alu_in[g]),
            .mdr_alu_n (mdr_alu_n[g]),
            .data_out  (data_out[g]),
            .req       (req[g]),
            .wr_rdn    (wr_rdn[g]),
            .burst_len (burst_len[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .beat_valid(beat_valid[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_re    (mem_re[g]),
            .mem_we    (mem_we[g]),
            .mem_rdata (mem_rdata[g]),
            .mar_m     (mar_m[g]),
            .mdr_m     (mdr_m[g])
        );
        // Memory contents are a keyed function of the address.
        assign mem_rdata[g] = mem_addr[g] ^ key[g];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input int d);
        req[d] = 1'b0; mar_en[d] = 1'b0; mar_sclr[d] = 1'b0; mdr_en[d] = 1'b0;
        wr_rdn[d] = 1'b0; burst_len[d] = 2'd0; addr_in[d] = 8'd0; alu_in[d] = 8'd0;
    endtask

    task automatic load(input int d, input bit sclr, input bit men, input logic [7:0] a,
                        input bit den, input logic [7:0] v);
        mar_sclr[d] = sclr; mar_en[d] = men; addr_in[d] = a; mdr_en[d] = den; alu_in[d] = v;
        if (sclr) mar_e[d] = 8'd0;
        else if (men) mar_e[d] = a;
        if (den) mdr_e[d] = v;
        @(posedge clk); #1;
        idle_inputs(d);
        @(negedge clk);
        chk("load_mar", mar_m[d], mar_e[d]);
        chk("load_mdr", mdr_m[d], mdr_e[d]);
        chk("load_mem_addr", mem_addr[d], mar_e[d]);
        chk("load_busy", busy[d], 0);
    endtask

    task automatic txn(input int d, input bit wr, input int blen, input bit ld_mar,
                       input logic [7:0] a, input bit ld_mdr, input logic [7:0] v,
                       input bit poke, input int rst_at);
        int ws, n, len, b;
        bit last;
        logic [7:0] ea, ed;
        ws  = (d == 0) ? 1 : 0;
        n   = blen + 1;
        len = n * (ws + 1);
        req[d] = 1'b1; wr_rdn[d] = wr; burst_len[d] = 2'(blen);
        mar_en[d] = ld_mar; addr_in[d] = a; mdr_en[d] = ld_mdr; alu_in[d] = v;
        if (ld_mar) mar_e[d] = a;
        if (ld_mdr) mdr_e[d] = v;
        @(posedge clk); #1;
        idle_inputs(d);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            b    = (c - 1) / (ws + 1);
            last = (c % (ws + 1)) == 0;
            ea   = mar_e[d] + 8'(b);
            ed   = (wr || b == 0) ? mdr_e[d] : ((ea - 8'd1) ^ key[d]);
            chk("busy", busy[d], 1);
            chk("done_early", done[d], 0);
            chk("mem_re", mem_re[d], !wr);
            chk("mem_we", mem_we[d], wr && last);
            chk("beat_valid", beat_valid[d], !wr && last);
            chk("mem_addr", mem_addr[d], ea);
            chk("mar_m", mar_m[d], ea);
            chk("mdr_m", mdr_m[d], ed);
            chk("mem_wdata", mem_wdata[d], ed);
            if (c == 1) begin
                alu_in[d] = 8'($urandom);
                mdr_alu_n[d] = 1'b1; #1;
                chk("mux_busy_mdr", data_out[d], ed);
                mdr_alu_n[d] = 1'b0; #1;
                chk("mux_busy_alu", data_out[d], alu_in[d]);
                mdr_alu_n[d] = 1'b1;
                alu_in[d] = 8'd0;
            end
            if (poke && c == 2) begin
                req[d] = 1'b1; mar_en[d] = 1'b1; addr_in[d] = ~ea;
                mdr_en[d] = 1'b1; alu_in[d] = ~ed; mar_sclr[d] = 1'b1;
            end
            if (c == rst_at) begin
                rst[d] = 1'b1;
                #1;
                chk("abort_no_done", done[d], 0);
                chk("abort_no_beat", beat_valid[d], 0);
                @(posedge clk); #1;
                rst[d] = 1'b0;
                idle_inputs(d);
                mar_e[d] = 8'd0;
                mdr_e[d] = 8'd0;
                @(negedge clk);
                chk("abort_busy", busy[d], 0);
                chk("abort_done", done[d], 0);
                chk("abort_mar", mar_m[d], 0);
                chk("abort_mdr", mdr_m[d], 0);
                chk("abort_mem_re", mem_re[d], 0);
                chk("abort_mem_we", mem_we[d], 0);
                @(negedge clk);
                chk("abort_done_later", done[d], 0);
                chk("abort_busy_later", busy[d], 0);
                return;
            end
            @(posedge clk); #1;
            idle_inputs(d);
        end
        @(negedge clk);
        chk("done", done[d], 1);
        chk("done_busy", busy[d], 1);
        chk("done_mem_re", mem_re[d], 0);
        chk("done_mem_we", mem_we[d], 0);
        chk("done_beat_valid", beat_valid[d], 0);
        mdr_e[d] = wr ? mdr_e[d] : ((mar_e[d] + 8'(n) - 8'd1) ^ key[d]);
        mar_e[d] = mar_e[d] + 8'(n);
        chk("final_mar", mar_m[d], mar_e[d]);
        chk("final_mdr", mdr_m[d], mdr_e[d]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_busy", busy[d], 0);
        chk("idle_after_done", done[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            mdr_alu_n[d] = 1'b1;
            key[d] = 8'd0;
            mar_e[d] = 8'd0;
            mdr_e[d] = 8'd0;
            idle_inputs(d);
        end

        // Reset held two cycles with random inputs
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                req[d] = 1'($urandom); mar_en[d] = 1'($urandom); mdr_en[d] = 1'($urandom);
                mar_sclr[d] = 1'($urandom); wr_rdn[d] = 1'($urandom);
                addr_in[d] = 8'($urandom); alu_in[d] = 8'($urandom); burst_len[d] = 2'($urandom);
            end
            @(negedge clk);
            chk("rst_done0", done[0], 0);
            chk("rst_done1", done[1], 0);
        end
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_beat_valid", beat_valid[d], 0);
            chk("rst_mem_re", mem_re[d], 0);
            chk("rst_mem_we", mem_we[d], 0);
            chk("rst_mem_addr", mem_addr[d], 0);
            chk("rst_mem_wdata", mem_wdata[d], 0);
            chk("rst_mar", mar_m[d], 0);
            chk("rst_mdr", mdr_m[d], 0);
            rst[d] = 1'b0;
            idle_inputs(d);
        end

        // Single read with one wait state
        key[0] = 8'hB5;
        load(0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
        txn(0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        chk("single_read_mdr", mdr_m[0], 8'hA5);
        chk("single_read_mar", mar_m[0], 8'h11);

        // Wrap-around block fill with loads in the request cycle
        txn(0, 1'b1, 3, 1'b1, 8'hFE, 1'b1, 8'h3C, 1'b0, 0);
        chk("fill_mar", mar_m[0], 8'h02);

        // Streaming read with no wait states
        key[1] = 8'h55;
        load(1, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00);
        txn(1, 1'b0, 2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        chk("stream_mdr", mdr_m[1], 8'h17);
        chk("stream_mar", mar_m[1], 8'h43);

        // Clear beats load, then busy protection and abort
        load(0, 1'b1, 1'b1, 8'h77, 1'b1, 8'h5A);
        key[0] = 8'h3E;
        txn(0, 1'b0, 2, 1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 0);
        txn(1, 1'b1, 3, 1'b1, 8'h80, 1'b1, 8'hC3, 1'b1, 0);
        txn(0, 1'b0, 3, 1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 3);

        // Idle mux check
        load(0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99);
        alu_in[0] = 8'h42;
        mdr_alu_n[0] = 1'b1; #1;
        chk("mux_idle_mdr", data_out[0], 8'h99);
        mdr_alu_n[0] = 1'b0; #1;
        chk("mux_idle_alu", data_out[0], 8'h42);
        mdr_alu_n[0] = 1'b1;
        alu_in[0] = 8'h00;

        // Randomized transactions on both instances
        for (int i = 0; i < 24; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            key[d] = 8'($urandom);
            txn(d, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom),
                1'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
